// File: rtl/lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator
//
// Load/store unit sitting between the execute stage and a word-wide data
// memory port. It takes one request at a time, issues word-aligned accesses,
// performs read-modify-write for byte/halfword stores, and returns extended
// load data with its destination register for writeback.
//
// Parameters:
//   WB_ZERO_SUPPRESS : when 1, a load to rd=0 completes with wb_we=0.
//
// Optional build macro:
//   LSU_TAG_CHECK_EN : compare mem_rd_in against the latched rd on every
//                      completing memory edge. A mismatch still completes the
//                      operation but forces wb_we=0 and pulses misalign_err.
//                      When undefined, mem_rd_in is ignored.
//
// Ports:
//   CLK, RST_X          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_we, req_op      1=store/0=load, funct3 size/sign code
//   req_addr, req_wd    byte address, right-aligned store data
//   req_rd              load destination register
//   mem_addr, mem_wd    word-aligned address, full write word
//   mem_we, mem_valid   write enable, access request
//   mem_rd              tag sent with the access
//   mem_loaded          read word from memory
//   mem_valid_in        access complete / read data valid
//   mem_rd_in           returned tag
//   wb_valid            one-cycle completion pulse
//   wb_we, wb_rd        register write enable and destination
//   wb_data             extended load data (0 for stores)
//   misalign_err        one-cycle error pulse coincident with wb_valid
// -----------------------------------------------------------------------------
module lsu_mem_initiator #(
    parameter int unsigned WB_ZERO_SUPPRESS = 1
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        mem_valid,
    output logic [4:0]  mem_rd,
    input  logic [31:0] mem_loaded,
    input  logic        mem_valid_in,
    input  logic [4:0]  mem_rd_in,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wd_q;      // only the low half is ever merged into memory
    logic [4:0]  rd_q;
    logic        tag_err_q; // tag mismatch seen on the read half of an RMW
    logic        tag_bad;

`ifdef LSU_TAG_CHECK_EN
    assign tag_bad = (mem_rd_in != rd_q);
`else
    logic unused_tag;
    assign unused_tag = ^mem_rd_in;
    assign tag_bad    = 1'b0;
`endif

    // Legal op for the given direction and alignment. Unsigned variants exist
    // only for loads; illegal codes are reported the same way as misalignment.
    function automatic logic op_ok(input logic we, input logic [2:0] op,
                                   input logic [1:0] off);
        logic ok;
        case (op)
            OP_B:    ok = 1'b1;
            OP_H:    ok = ~off[0];
            OP_W:    ok = (off == 2'b00);
            OP_BU:   ok = ~we;
            OP_HU:   ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] op,
                                                 input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (op)
            OP_B:    r = {{24{b[7]}}, b};
            OP_BU:   r = {24'h0, b};
            OP_H:    r = {{16{h[15]}}, h};
            OP_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Little-endian lane insert: byte k occupies bits 8k+7:8k.
    function automatic logic [31:0] merge_store(input logic [2:0] op,
                                                input logic [1:0] off,
                                                input logic [31:0] old,
                                                input logic [15:0] wd);
        logic [31:0] mask;
        logic [31:0] data;
        if (op == OP_H) begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            data = {2{wd}};
        end else begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {4{wd[7:0]}};
        end
        return (old & ~mask) | (data & mask);
    endfunction

    logic load_we;
    assign load_we = !((WB_ZERO_SUPPRESS != 0) && (rd_q == 5'd0));

    // NOTE: state and outputs are registers updated with non-blocking
    // assignments; the asynchronous reset clears mem_valid the moment RST_X
    // falls, so a write in flight is never presented at the next edge.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state        <= S_IDLE;
            op_q         <= 3'b000;
            off_q        <= 2'b00;
            wd_q         <= 16'h0;
            rd_q         <= 5'd0;
            tag_err_q    <= 1'b0;
            req_ready    <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wd       <= 32'h0;
            mem_we       <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= 5'd0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only on the
            // edge entering RESP, which makes them exactly one cycle wide.
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        off_q     <= req_addr[1:0];
                        wd_q      <= req_wd[15:0];
                        rd_q      <= req_rd;
                        tag_err_q <= 1'b0;
                        wb_rd     <= req_rd;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_rd    <= req_rd;
                        if (!op_ok(req_we, req_op, req_addr[1:0])) begin
                            state        <= S_RESP;
                            wb_valid     <= 1'b1;
                            misalign_err <= 1'b1;
                            wb_we        <= 1'b0;
                            wb_data      <= 32'h0;
                        end else if (!req_we) begin
                            state     <= S_LD;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                        end else if (req_op == OP_W) begin
                            state     <= S_WR;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wd    <= req_wd;
                        end else begin
                            state     <= S_RMW_RD;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                        end
                    end
                end

                S_LD: begin
                    if (mem_valid_in) begin
                        state        <= S_RESP;
                        mem_valid    <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_we        <= load_we && !tag_bad;
                        wb_data      <= extract_load(op_q, off_q, mem_loaded);
                        misalign_err <= tag_bad;
                    end
                end

                // mem_valid stays high into WR; only mem_we and mem_wd change.
                S_RMW_RD: begin
                    if (mem_valid_in) begin
                        state     <= S_WR;
                        mem_we    <= 1'b1;
                        mem_wd    <= merge_store(op_q, off_q, mem_loaded, wd_q);
                        tag_err_q <= tag_bad;
                    end
                end

                S_WR: begin
                    if (mem_valid_in) begin
                        state        <= S_RESP;
                        mem_valid    <= 1'b0;
                        mem_we       <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_we        <= 1'b0;
                        wb_data      <= 32'h0;
                        misalign_err <= tag_bad || tag_err_q;
                    end
                end

                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    wb_we     <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    mem_valid <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit between the execute stage and the word-wide data-memory port.
- Accepts one load/store request at a time and issues word-aligned accesses to the memory stage.
- Performs read-modify-write for byte and halfword stores.
- Extracts and extends loaded data, then returns it with the destination register for writeback.

Parameters:
- WB_ZERO_SUPPRESS, 1, when 1 a load to rd=0 completes with wb_we=0.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST_X  in  1  asynchronous active-low reset
- req_valid  in  1  execute-stage request valid
- req_ready  out  1  LSU can accept a request (IDLE only)
- req_we  in  1  1=store, 0=load
- req_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wd  in  32  store data, right-aligned
- req_rd  in  5  load destination register
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wd  out  32  full write word
- mem_we  out  1  write enable
- mem_valid  out  1  access request
- mem_rd  out  5  tag sent with access (req_rd)
- mem_loaded  in  32  read word
- mem_valid_in  in  1  access complete / read data valid
- mem_rd_in  in  5  returned tag
- wb_valid  out  1  one-cycle completion pulse (loads and stores)
- wb_we  out  1  register write enable, meaningful with wb_valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- misalign_err  out  1  one-cycle pulse with wb_valid on a misaligned request

Behaviour:
- Reset values: req_ready=0 while RST_X low, 1 after in IDLE; all other outputs 0; state IDLE.
- Reset is asynchronous: mem_valid drops immediately, so an in-flight write is never committed.
- Request is accepted at a rising edge with req_valid && req_ready; op, addr, wd and rd are latched.
- Alignment: H needs addr[0]=0; W needs addr[1:0]=00. Otherwise go to RESP with misalign_err=1, wb_we=0 and no memory access.
- An invalid req_op is treated as misaligned.
- States and transitions:
  - IDLE: accept a request. Load -> LD; SW -> WR; SB/SH -> RMW_RD; misaligned -> RESP.
  - LD: mem_valid=1, mem_we=0. At an edge with mem_valid_in=1, capture mem_loaded -> RESP.
  - RMW_RD: mem_valid=1, mem_we=0. At an edge with mem_valid_in=1, merge the store byte/half into mem_loaded at byte lane addr[1:0] (little-endian; byte k = bits 8k+7:8k) -> WR.
  - WR: mem_valid=1, mem_we=1, mem_wd = merged word (SW: req_wd). At an edge with mem_valid_in=1 -> RESP.
  - RESP: wb_valid=1 for exactly one cycle -> IDLE.
- mem_valid has at most one edge of dead time between RMW_RD and WR; it stays high across that boundary with mem_we rising.
- Wait states: while mem_valid_in=0, the state holds and all mem_* outputs stay stable.
- Load extract: byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]).
  - B/H sign-extend; BU/HU zero-extend; W is passed through.
- Stores: wb_we=0, wb_data=0.
- Loads: wb_we=1 except when rd=0 and WB_ZERO_SUPPRESS=1.
- Latency with zero wait states, accept at edge T:
  - Load/SW: mem access in cycle T+1, wb_valid in T+2, req_ready again in T+3.
  - SB/SH: read in T+1, write in T+2, wb_valid in T+3.
  - Misaligned: wb_valid in T+1.
- req_valid is ignored outside IDLE.

Optional Feature:
- LSU_TAG_CHECK_EN defined:
  - Every completing edge compares mem_rd_in against the latched rd.
  - On mismatch, the op still completes; wb_we is forced to 0 and misalign_err pulses in RESP (reused as the generic error flag).
- Undefined: mem_rd_in is ignored.

Test Plan:
- Mem word 0x100=0x8877_6655; LW addr 0x100 rd=5 -> T+2 wb_valid=1, wb_rd=5, wb_data=0x8877_6655, wb_we=1.
- Same word; LB addr 0x103 -> wb_data=0xFFFF_FF88. LBU addr 0x103 -> 0x0000_0088. LHU addr 0x102 -> 0x0000_8877.
- SB addr 0x101 wd=0xAB on word 0x8877_6655:
  - T+1: mem_valid=1, mem_we=0.
  - T+2: mem_we=1, mem_wd=0x8877_AB55.
  - Readback via LW gives 0x8877_AB55.
- LH addr 0x103 -> next cycle wb_valid=1, misalign_err=1, wb_we=0; mem_valid never asserted.
- LW with mem_valid_in held 0 for 3 cycles -> mem_addr/mem_valid stable throughout; wb_valid 1 cycle after mem_valid_in rises; req_ready low meanwhile.
- SH in WR state, RST_X pulled low mid-cycle -> mem_valid=0 immediately, word unchanged on readback; after release req_ready=1, state IDLE.
